// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for DIV/DIVU; quotient on div_lo, remainder on div_hi.
// Optional DIV_SHORTCUT_EN: finish in one edge when |dividend| < |divisor|.
module ex_div #(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] opdata1,
    input  logic [WIDTH-1:0] opdata2,
    input  logic             annul,
    output logic [WIDTH-1:0] div_lo,
    output logic [WIDTH-1:0] div_hi,
    output logic             ready,
    output logic             stall_req
);

    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {FREE, DIV_ZERO, ON, END} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic [WIDTH-1:0] div_lo_q;
    logic [WIDTH-1:0] div_hi_q;
    logic             ready_q;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic en);
        return (en && v[WIDTH-1]) ? ((~v) + WIDTH'(1)) : v;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
        return en ? ((~v) + WIDTH'(1)) : v;
    endfunction

    logic [WIDTH-1:0] op1_abs;
    logic [WIDTH-1:0] op2_abs;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    assign op1_abs = abs_val(opdata1, signed_div);
    assign op2_abs = abs_val(opdata2, signed_div);

    // The shifted remainder can exceed WIDTH bits for large unsigned divisors, so trial in WIDTH+1.
    assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    assign rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
    assign quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FREE;
            cnt_q    <= '0;
            div_lo_q <= '0;
            div_hi_q <= '0;
            ready_q  <= 1'b0;
        end else if (annul && state_q != FREE) begin
            state_q  <= FREE;
            div_lo_q <= '0;
            div_hi_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                FREE: begin
                    if (start && !annul) begin
                        if (opdata2 == '0) begin
                            state_q <= DIV_ZERO;
                        end
`ifdef DIV_SHORTCUT_EN
                        else if (op1_abs < op2_abs) begin
                            state_q  <= END;
                            div_lo_q <= '0;
                            div_hi_q <= opdata1;
                            ready_q  <= 1'b1;
                        end
`endif
                        else begin
                            state_q   <= ON;
                            cnt_q     <= '0;
                            rem_q     <= '0;
                            quo_q     <= op1_abs;
                            dvs_q     <= op2_abs;
                            neg_quo_q <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                            neg_rem_q <= signed_div & opdata1[WIDTH-1];
                        end
                    end
                end
                DIV_ZERO: begin
                    state_q  <= END;
                    div_lo_q <= '0;
                    div_hi_q <= '0;
                    ready_q  <= 1'b1;
                end
                ON: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(ITER - 1)) begin
                        state_q  <= END;
                        div_lo_q <= cond_neg(quo_d, neg_quo_q);
                        div_hi_q <= cond_neg(rem_d, neg_rem_q);
                        ready_q  <= 1'b1;
                    end
                end
                END: begin
                    if (!start) begin
                        state_q  <= FREE;
                        div_lo_q <= '0;
                        div_hi_q <= '0;
                        ready_q  <= 1'b0;
                    end
                end
                default: state_q <= FREE;
            endcase
        end
    end

    assign div_lo    = div_lo_q;
    assign div_hi    = div_hi_q;
    assign ready     = ready_q;
    assign stall_req = start & ~ready_q;

endmodule
